// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter giving four requesters bursts of writes
// into one FIFO write port. A tenure lasts until the grantee drops its request,
// completes BURST transfers, or (optionally) stalls too long behind a full FIFO.
// Optional feature: define FIFO_WR_ARB_TIMEOUT_EN to add the stall timeout.
//
// state | meaning
// IDLE  | no grant outstanding, waiting for any request
// GRANT | one requester owns the write port; gnt is one-hot
module fifo_wr_arbiter #(
   parameter int Width = 4,
   parameter int BURST = 4
) (
   input  logic                 wclk,
   input  logic                 wreset,
   input  logic [3:0]           req,
   input  logic [4*Width-1:0]   req_data,
   input  logic                 full,
   output logic [3:0]           gnt,
   output logic                 wen,
   output logic [Width-1:0]     wdata,
   output logic                 busy,
   output logic                 timeout
);

   typedef enum logic {IDLE, GRANT} state_t;

   localparam logic [3:0] BURST_LAST = 4'(BURST - 1);

   state_t     state;
   logic       armed;
   logic [1:0] last_granted;
   logic [3:0] burst_cnt;
   logic [1:0] cur;
   logic       owner_req;
   logic       drop;
   logic       burst_hit;
   logic       stall_hit;
   logic       tenure_end;
   logic [3:0] next_gnt;

   // Nearest requester after l wins; l itself is considered last.
   function automatic logic [3:0] rr_pick(input logic [3:0] r, input logic [1:0] l);
      logic [1:0] idx;
      rr_pick = '0;
      for (int k = 4; k >= 1; k--) begin
         idx = l + 2'(k);
         if (r[idx]) rr_pick = 4'b0001 << idx;
      end
   endfunction

   // Encode the one-hot grant and select the grantee's data.
   always_comb begin
      cur   = '0;
      wdata = '0;
      for (int i = 0; i < 4; i++) begin
         if (gnt[i]) begin
            cur   = 2'(i);
            wdata = req_data[i*Width +: Width];
         end
      end
   end

   assign owner_req  = |(gnt & req);
   assign wen        = owner_req & ~full;
   assign drop       = ~owner_req;
   assign burst_hit  = wen && (burst_cnt == BURST_LAST);
   assign tenure_end = drop | burst_hit | stall_hit;
   assign next_gnt   = rr_pick(req, cur);
   assign busy       = (state == GRANT);

`ifdef FIFO_WR_ARB_TIMEOUT_EN
   logic [3:0] stall_cnt;

   // The fifteenth consecutive stalled cycle ends the tenure.
   assign stall_hit = (state == GRANT) && full && (stall_cnt == 4'd14);

   // Consecutive full cycles within one tenure; timeout pulses after an abort.
   always_ff @(posedge wclk or negedge wreset) begin
      if (!wreset) begin
         stall_cnt <= '0;
         timeout   <= 1'b0;
      end else begin
         timeout <= stall_hit;
         if ((state != GRANT) || !full || tenure_end)
            stall_cnt <= '0;
         else
            stall_cnt <= stall_cnt + 4'd1;
      end
   end
`else
   assign stall_hit = 1'b0;
   assign timeout   = 1'b0;
`endif

   // Arbitration FSM; the first edge after reset release only arms it.
   always_ff @(posedge wclk or negedge wreset) begin
      if (!wreset) begin
         state        <= IDLE;
         gnt          <= '0;
         burst_cnt    <= '0;
         last_granted <= 2'd3;
         armed        <= 1'b0;
      end else begin
         armed <= 1'b1;
         case (state)
            IDLE: begin
               if (armed && (req != 4'b0000)) begin
                  gnt       <= rr_pick(req, last_granted);
                  burst_cnt <= '0;
                  state     <= GRANT;
               end
            end
            GRANT: begin
               if (tenure_end) begin
                  last_granted <= cur;
                  burst_cnt    <= '0;
                  if (req != 4'b0000) begin
                     gnt <= next_gnt;
                  end else begin
                     gnt   <= '0;
                     state <= IDLE;
                  end
               end else if (wen) begin
                  burst_cnt <= burst_cnt + 4'd1;
               end
            end
            default: begin
               state <= IDLE;
               gnt   <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: vector table, multi-cycle corner sequences and a
// randomized run against a tenure-level reference model.
module tb_fifo_wr_arbiter;

   localparam int W     = 4;
   localparam int BURST = 4;

`ifdef FIFO_WR_ARB_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic           wclk = 1'b0;
   logic           wreset;
   logic [3:0]     req;
   logic [4*W-1:0] req_data;
   logic           full;
   logic [3:0]     gnt;
   logic           wen;
   logic [W-1:0]   wdata;
   logic           busy;
   logic           timeout;

   int n_cmp = 0;
   int n_err = 0;

   fifo_wr_arbiter #(.Width(W), .BURST(BURST)) dut (
      .wclk     (wclk),
      .wreset   (wreset),
      .req      (req),
      .req_data (req_data),
      .full     (full),
      .gnt      (gnt),
      .wen      (wen),
      .wdata    (wdata),
      .busy     (busy),
      .timeout  (timeout)
   );

   always #5 wclk = ~wclk;

   typedef struct {
      logic [3:0]   req;
      logic         full;
      logic [3:0]   gnt;
      logic         wen;
      logic [W-1:0] wdata;
      logic         busy;
   } vec_t;

   vec_t tbl[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void add(input logic [3:0] r, input logic f, input logic [3:0] g,
                               input logic we, input logic [W-1:0] wd, input logic b);
      vec_t v;
      v.req = r; v.full = f; v.gnt = g; v.wen = we; v.wdata = wd; v.busy = b;
      tbl.push_back(v);
   endfunction

   // Leaves the bench one time unit after an edge with reset just released.
   task automatic do_reset();
      wreset = 1'b0;
      req    = 4'b0000;
      full   = 1'b0;
      repeat (2) @(posedge wclk);
      #1;
      wreset = 1'b1;
   endtask

   function automatic int pick(input logic [3:0] r, input int l);
      for (int k = 1; k <= 4; k++)
         if (r[(l + k) % 4]) return (l + k) % 4;
      return -1;
   endfunction

   // Reference model state: who owns the port and how far the tenure has gone.
   int owner, writes, stalls, last;
   bit synced, to_exp;

   initial begin
      logic [3:0]   e_gnt;
      logic         e_wen;
      logic [W-1:0] e_wdata;
      logic         w, done;
      int           s;

      req_data = 16'h9C3A;   // r0=A r1=3 r2=C r3=9

      // ---------------- reset values (inputs active during reset)
      wreset = 1'b0;
      req    = 4'b1111;
      full   = 1'b0;
      repeat (3) @(posedge wclk);
      #3;
      check("reset_gnt", 32'(gnt), 32'h0);
      check("reset_wen", 32'(wen), 32'h0);
      check("reset_busy", 32'(busy), 32'h0);
      check("reset_wdata", 32'(wdata), 32'h0);
      check("reset_timeout", 32'(timeout), 32'h0);

      // ---------------- vector table
      add(4'b0001, 0, 4'b0000, 0, 4'h0, 0);   // sync edge pending
      add(4'b0001, 0, 4'b0000, 0, 4'h0, 0);
      for (int i = 0; i < 5; i++) add(4'b0001, 0, 4'b0001, 1, 4'hA, 1);  // sole requester re-granted
      add(4'b0000, 0, 4'b0001, 0, 4'hA, 1);   // drop ends tenure
      add(4'b1111, 0, 4'b0000, 0, 4'h0, 0);
      for (int i = 0; i < 4; i++) add(4'b1111, 0, 4'b0010, 1, 4'h3, 1);
      for (int i = 0; i < 4; i++) add(4'b1111, 0, 4'b0100, 1, 4'hC, 1);
      for (int i = 0; i < 4; i++) add(4'b1111, 0, 4'b1000, 1, 4'h9, 1);
      for (int i = 0; i < 4; i++) add(4'b1111, 0, 4'b0001, 1, 4'hA, 1);
      add(4'b1111, 0, 4'b0010, 1, 4'h3, 1);
      for (int i = 0; i < 3; i++) add(4'b1111, 1, 4'b0010, 0, 4'h3, 1);  // stall freezes count
      for (int i = 0; i < 3; i++) add(4'b1111, 0, 4'b0010, 1, 4'h3, 1);
      add(4'b0000, 0, 4'b0100, 0, 4'hC, 1);
      add(4'b0000, 0, 4'b0000, 0, 4'h0, 0);

      @(posedge wclk);
      #1;
      wreset = 1'b1;
      for (int i = 0; i < tbl.size(); i++) begin
         req  = tbl[i].req;
         full = tbl[i].full;
         #4;
         check($sformatf("tbl%0d_gnt", i), 32'(gnt), 32'(tbl[i].gnt));
         check($sformatf("tbl%0d_wen", i), 32'(wen), 32'(tbl[i].wen));
         check($sformatf("tbl%0d_wdata", i), 32'(wdata), 32'(tbl[i].wdata));
         check($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].busy));
         check($sformatf("tbl%0d_timeout", i), 32'(timeout), 32'h0);
         @(posedge wclk);
         #1;
      end

      // ---------------- asynchronous reset during the second write
      do_reset();
      req = 4'b0001;
      repeat (3) begin
         @(posedge wclk);
         #1;
      end
      #2;
      check("midrst_pre_wen", 32'(wen), 32'h1);
      wreset = 1'b0;
      #1;
      check("midrst_gnt", 32'(gnt), 32'h0);
      check("midrst_wen", 32'(wen), 32'h0);
      check("midrst_busy", 32'(busy), 32'h0);
      req = 4'b1111;
      @(posedge wclk);
      #1;
      wreset = 1'b1;
      @(posedge wclk);
      #1;
      check("postrst_sync_gnt", 32'(gnt), 32'h0);
      @(posedge wclk);
      #1;
      check("postrst_first_gnt", 32'(gnt), 32'h1);

      // ---------------- long full stall under grant
      do_reset();
      req = 4'b0101;
      repeat (2) begin
         @(posedge wclk);
         #1;
      end
      s = 1;
      while (s <= 20) begin
         full = 1'b1;
         #4;
         if (s == 1)  check("stall_hold_gnt", 32'(gnt), 32'h1);
         if (s == 15) check("stall15_gnt", 32'(gnt), 32'h1);
         if (s == 15) check("stall15_timeout", 32'(timeout), 32'h0);
         if (s == 16) check("stall16_gnt", 32'(gnt), TO_EN ? 32'h4 : 32'h1);
         if (s == 16) check("stall16_timeout", 32'(timeout), TO_EN ? 32'h1 : 32'h0);
         if (s == 17) check("stall17_timeout", 32'(timeout), 32'h0);
         if (s == 20) check("stall20_gnt", 32'(gnt), TO_EN ? 32'h4 : 32'h1);
         if (s == 20) check("stall20_wen", 32'(wen), 32'h0);
         @(posedge wclk);
         #1;
         s++;
      end
      full = 1'b0;

      // ---------------- randomized run against the reference model
      do_reset();
      owner = -1; writes = 0; stalls = 0; last = 3; synced = 1'b0; to_exp = 1'b0;
      req = 4'b0000;
      for (int c = 0; c < 3000; c++) begin
         for (int b = 0; b < 4; b++)
            if ($urandom_range(0, 5) == 0) req[b] = ~req[b];
         full     = ($urandom_range(0, 4) == 0);
         if ($urandom_range(0, 199) == 0) full = 1'b1;
         req_data = 16'($urandom);
         #4;
         e_gnt   = (owner < 0) ? 4'b0000 : (4'b0001 << owner);
         e_wen   = (owner >= 0) && req[owner] && !full;
         e_wdata = (owner >= 0) ? req_data[owner*W +: W] : '0;
         check("rnd_gnt", 32'(gnt), 32'(e_gnt));
         check("rnd_wen", 32'(wen), 32'(e_wen));
         check("rnd_wdata", 32'(wdata), 32'(e_wdata));
         check("rnd_busy", 32'(busy), (owner >= 0) ? 32'h1 : 32'h0);
         check("rnd_timeout", 32'(timeout), 32'(to_exp));
         check("rnd_onehot", 32'($onehot0(gnt)), 32'h1);

         to_exp = 1'b0;
         if (owner < 0) begin
            if (synced && req != 4'b0000) begin
               owner = pick(req, last);
               writes = 0;
               stalls = 0;
            end
         end else begin
            w = req[owner] && !full;
            if (w) writes++;
            stalls = full ? stalls + 1 : 0;
            done = !req[owner] || (writes == BURST) || (TO_EN && stalls == 15);
            if (done) begin
               to_exp = TO_EN && (stalls == 15);
               last   = owner;
               owner  = (req != 4'b0000) ? pick(req, last) : -1;
               writes = 0;
               stalls = 0;
            end
         end
         synced = 1'b1;
         @(posedge wclk);
         #1;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
